// File: rtl/bs_mac_pkg.sv
// bs_mac_pkg
// Shared types and helpers for the bit-serial MAC array.
//   prec_e    : precision select encoding carried on the prec bus field
//   state_e   : controller states (IDLE, RUN)
//   sat_t     : result of a saturating add (clamped sum + overflow flag)
//   prec_bits : maps a precision code to its serial length in bits
//   sat_add   : signed add that clamps to a chosen accumulator width
package bs_mac_pkg;

   // Code 2'b11 is reserved. It gets its own member so that casting the raw
   // bus field to prec_e always gives a legal enum value. It runs as 8-bit.
   typedef enum logic [1:0] {
      PREC8     = 2'b00,
      PREC4     = 2'b01,
      PREC2     = 2'b10,
      PREC_RSVD = 2'b11
   } prec_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // Working width of the saturating adder. It must exceed the widest
   // accumulator so that the raw sum can never wrap before it is clamped.
   localparam int SAT_W = 64;

   typedef struct packed {
      logic signed [SAT_W-1:0] sum;
      logic                    ovf;
   } sat_t;

   // Serial length of one operation. The reserved code falls back to 8 bits.
   function automatic logic [3:0] prec_bits(prec_e p);
      case (p)
         PREC4:   return 4'd4;
         PREC2:   return 4'd2;
         default: return 4'd8;
      endcase
   endfunction

   // Adds two sign-extended operands. The result is clamped to the signed
   // range of a 'width'-bit register, and ovf reports whether clamping happened.
   function automatic sat_t sat_add(logic signed [SAT_W-1:0] x,
                                    logic signed [SAT_W-1:0] y,
                                    int unsigned             width);
      logic signed [SAT_W-1:0] s;
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      sat_t                    r;
      s  = x + y;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (s > hi) begin
         r.sum = hi;
         r.ovf = 1'b1;
      end else if (s < lo) begin
         r.sum = lo;
         r.ovf = 1'b1;
      end else begin
         r.sum = s;
         r.ovf = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/bs_mac_array_if.sv
// bs_mac_array_if
// Bundle that connects the operand fetch side and the requant side to the
// MAC array.
//   master : drives in_valid, a, w, prec, acc_clr; observes all status/results
//   slave  : the engine; drives in_ready, busy, count, out_valid, product,
//            accum, ovf
// Lane i occupies a/w[i*DW +: DW], product[i*2*DW +: 2*DW],
// accum[i*ACCW +: ACCW] and ovf[i].
interface bs_mac_array_if #(
   parameter int LANES = 4,
   parameter int DW    = 8,
   parameter int ACCW  = 20
);
   logic                    in_valid;
   logic                    in_ready;
   logic [LANES*DW-1:0]     a;
   logic [LANES*DW-1:0]     w;
   logic [1:0]              prec;
   logic                    acc_clr;
   logic                    busy;
   logic [2:0]              count;
   logic                    out_valid;
   logic [LANES*2*DW-1:0]   product;
   logic [LANES*ACCW-1:0]   accum;
   logic [LANES-1:0]        ovf;

   modport master (
      output in_valid, a, w, prec, acc_clr,
      input  in_ready, busy, count, out_valid, product, accum, ovf
   );

   modport slave (
      input  in_valid, a, w, prec, acc_clr,
      output in_ready, busy, count, out_valid, product, accum, ovf
   );
endinterface

// File: rtl/bs_mac_lane.sv
// bs_mac_lane
// Datapath for one MAC lane. It multiplies a sign-extended activation by a
// weight that is consumed LSB first, one bit per cycle. The finished product
// is then folded into a saturating accumulator.
//   clk, rstn      : clock, async active-low reset
//   load           : latch a_in/w_in and start a new product (accept edge)
//   step           : a serial cycle is in progress
//   last           : this serial cycle handles the weight MSB
//   bit_idx        : current weight bit index
//   p_load         : precision (8/4/2) of the operands being loaded
//   a_in, w_in     : this lane's operand fields
//   acc_clr        : synchronous clear of accum and ovf
//   product        : last completed signed product
//   accum, ovf     : saturating running sum and its sticky overflow flag
module bs_mac_lane
   import bs_mac_pkg::*;
#(
   parameter int DW   = 8,
   parameter int ACCW = 20
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              load,
   input  logic              step,
   input  logic              last,
   input  logic [2:0]        bit_idx,
   input  logic [3:0]        p_load,
   input  logic [DW-1:0]     a_in,
   input  logic [DW-1:0]     w_in,
   input  logic              acc_clr,
   output logic [2*DW-1:0]   product,
   output logic [ACCW-1:0]   accum,
   output logic              ovf
);

   localparam int PW = 2 * DW;

   logic signed [PW-1:0] a_ext_q;
   logic signed [PW-1:0] a_ext_d;
   logic signed [PW-1:0] partial_q;
   logic signed [PW-1:0] partial_d;
   logic signed [PW-1:0] term;
   logic        [DW-1:0] w_sr_q;
   logic        [DW-1:0] a_shl;
   logic signed [DW-1:0] a_nar;
   logic        [ACCW-1:0] acc_base;
   sat_t                 sres;
   int                   shamt;
   logic                 sat_unused;

   // Sign-extend the low P bits of the activation. The field is pushed to the
   // top of the DW-bit word and then shifted back arithmetically, which
   // replicates bit P-1 upward. The result is widened to the product width.
   always_comb begin
      shamt   = DW - int'(p_load);
      a_shl   = a_in << shamt;
      a_nar   = $signed(a_shl) >>> shamt;
      a_ext_d = {{DW{a_nar[DW-1]}}, a_nar};
   end

   // One shift-and-add step. The weight MSB carries negative weight in
   // two's complement, so its term is subtracted instead of added.
   // The accumulator input is zeroed by acc_clr. When a clear lands on the
   // same edge as a completed product, the result is "clear, then add".
   always_comb begin
      term      = w_sr_q[0] ? (a_ext_q <<< bit_idx) : '0;
      partial_d = last ? (partial_q - term) : (partial_q + term);
      acc_base  = acc_clr ? '0 : accum;
      sres      = sat_add({{(SAT_W-ACCW){acc_base[ACCW-1]}}, acc_base},
                          {{(SAT_W-PW){partial_d[PW-1]}}, partial_d},
                          ACCW);
   end

   // Only the low ACCW bits of the clamped sum are kept. Clamping guarantees
   // that the upper bits are plain sign copies.
   assign sat_unused = ^sres.sum[SAT_W-1:ACCW];

   // Serial state. A load always wins, so that a new operand set accepted on
   // the final cycle of the previous one restarts cleanly.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         a_ext_q   <= '0;
         w_sr_q    <= '0;
         partial_q <= '0;
      end else if (load) begin
         a_ext_q   <= a_ext_d;
         w_sr_q    <= w_in;
         partial_q <= '0;
      end else if (step) begin
         w_sr_q    <= w_sr_q >> 1;
         partial_q <= partial_d;
      end
   end

   // Result registers. They update only when a product completes, or when a
   // standalone clear arrives. A clear never touches the serial state above.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         product <= '0;
         accum   <= '0;
         ovf     <= 1'b0;
      end else if (step && last) begin
         product <= partial_d;
         accum   <= sres.sum[ACCW-1:0];
         ovf     <= (ovf & ~acc_clr) | sres.ovf;
      end else if (acc_clr) begin
         accum   <= '0;
         ovf     <= 1'b0;
      end
   end

endmodule

// File: rtl/bs_mac_array.sv
// bs_mac_array
// Multi-lane bit-serial signed MAC engine with runtime precision 8/4/2.
// One serial controller sequences LANES identical datapath lanes.
//   clk, rstn : clock, async active-low reset
//   bus       : slave side of bs_mac_array_if (operand handshake, precision,
//               accumulator clear, busy/count status, results)
module bs_mac_array
   import bs_mac_pkg::*;
#(
   parameter int LANES = 4,
   parameter int DW    = 8,
   parameter int ACCW  = 20
) (
   input  logic           clk,
   input  logic           rstn,
   bs_mac_array_if.slave  bus
);

   state_e      state_q;
   state_e      state_d;
   logic [2:0]  count_q;
   logic [3:0]  p_q;
   logic [3:0]  p_new;
   logic        busy;
   logic        last;
   logic        in_ready;
   logic        accept;
   logic        out_valid_q;

   logic [2*DW-1:0]         prod_l [LANES];
   logic [ACCW-1:0]         acc_l  [LANES];
   logic [LANES-1:0]        ovf_l;
   logic [LANES*2*DW-1:0]   prod_flat;
   logic [LANES*ACCW-1:0]   acc_flat;

   assign p_new = prec_bits(prec_e'(bus.prec));

   // Controller outputs. The engine is ready whenever it is idle, and also on
   // the last serial cycle, so that back-to-back sets see no bubble.
   always_comb begin
      busy     = (state_q == RUN);
      last     = busy && ({1'b0, count_q} == (p_q - 4'd1));
      in_ready = !busy || last;
      accept   = bus.in_valid && in_ready;
   end

   // Next-state logic. After the last bit, the engine stays in RUN only if a
   // new set is accepted on that same cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = RUN;
         RUN:     if (last)   state_d = accept ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Bit counter and latched precision. prec is sampled only on accept, so a
   // change mid-operation cannot alter the serial length.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count_q <= '0;
         p_q     <= 4'd8;
      end else if (accept) begin
         count_q <= '0;
         p_q     <= p_new;
      end else if (busy) begin
         count_q <= last ? 3'd0 : count_q + 3'd1;
      end
   end

   // out_valid is registered from the last serial cycle. It rises together
   // with the product/accum update and lasts exactly one cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) out_valid_q <= 1'b0;
      else       out_valid_q <= last;
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      bs_mac_lane #(
         .DW   (DW),
         .ACCW (ACCW)
      ) u_lane (
         .clk     (clk),
         .rstn    (rstn),
         .load    (accept),
         .step    (busy),
         .last    (last),
         .bit_idx (count_q),
         .p_load  (p_new),
         .a_in    (bus.a[i*DW +: DW]),
         .w_in    (bus.w[i*DW +: DW]),
         .acc_clr (bus.acc_clr),
         .product (prod_l[i]),
         .accum   (acc_l[i]),
         .ovf     (ovf_l[i])
      );
   end

   // Pack the per-lane results back into the flat bus fields.
   always_comb begin
      prod_flat = '0;
      acc_flat  = '0;
      for (int i = 0; i < LANES; i++) begin
         prod_flat[i*2*DW +: 2*DW] = prod_l[i];
         acc_flat[i*ACCW +: ACCW]  = acc_l[i];
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.busy      = busy;
   assign bus.count     = count_q;
   assign bus.out_valid = out_valid_q;
   assign bus.product   = prod_flat;
   assign bus.accum     = acc_flat;
   assign bus.ovf       = ovf_l;

endmodule

// File: tb/tb_bs_mac_array.sv
// tb_bs_mac_array
// Directed, self-checking bench for bs_mac_array with hand-computed vectors
// (LANES=4, DW=8, ACCW=20).
module tb_bs_mac_array;

   localparam int LANES = 4;
   localparam int DW    = 8;
   localparam int ACCW  = 20;

   logic clk = 1'b0;
   logic rstn;

   int n_compared   = 0;
   int n_mismatched = 0;

   always #5 clk = ~clk;

   bs_mac_array_if #(.LANES(LANES), .DW(DW), .ACCW(ACCW)) bus ();

   bs_mac_array #(.LANES(LANES), .DW(DW), .ACCW(ACCW)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one operand set for a single cycle. Callers invoke this only when
   // the engine is ready.
   task automatic launch(input logic [31:0] av, input logic [31:0] wv,
                         input logic [1:0] p);
      bus.a        = av;
      bus.w        = wv;
      bus.prec     = p;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
   endtask

   // Wait, with a cycle budget, for out_valid. Returns the cycles elapsed.
   task automatic wait_out(output int cycles);
      cycles = 0;
      while (bus.out_valid !== 1'b1 && cycles < 64) begin
         tick();
         cycles++;
      end
   endtask

   task automatic pulse_clr();
      bus.acc_clr = 1'b1;
      tick();
      bus.acc_clr = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (3) tick();
      rstn = 1'b1;
      tick();
      n_compared++;
      if (bus.in_ready !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL reset_in_ready: got %b want 1", bus.in_ready);
      end
      n_compared++;
      if (bus.busy !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL reset_busy: got %b want 0", bus.busy);
      end
      n_compared++;
      if (bus.count !== 3'd0) begin
         n_mismatched++;
         $display("[TB] FAIL reset_count: got %0d want 0", bus.count);
      end
      n_compared++;
      if (bus.out_valid !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL reset_out_valid: got %b want 0", bus.out_valid);
      end
      n_compared++;
      if (bus.product !== '0 || bus.accum !== '0 || bus.ovf !== '0) begin
         n_mismatched++;
         $display("[TB] FAIL reset_results: got prod=%h acc=%h ovf=%b want 0",
                  bus.product, bus.accum, bus.ovf);
      end
   endtask

   task automatic test_8b_basic();
      int cyc;
      logic [15:0] ep [4];
      logic [19:0] ea [4];
      ep = '{16'h0406, 16'h4000, 16'hF85F, 16'hFFFF};
      ea = '{20'h00406, 20'h04000, 20'hFF85F, 20'hFFFFF};
      pulse_clr();
      launch({8'hFF, 8'h3F, 8'h80, 8'h67}, {8'h01, 8'hE1, 8'h80, 8'h0A}, 2'b00);
      wait_out(cyc);
      n_compared++;
      if (cyc != 8) begin
         n_mismatched++;
         $display("[TB] FAIL b8_latency: got %0d want 8", cyc);
      end
      for (int i = 0; i < LANES; i++) begin
         n_compared++;
         if (bus.product[i*16 +: 16] !== ep[i]) begin
            n_mismatched++;
            $display("[TB] FAIL b8_product[%0d]: got %h want %h", i, bus.product[i*16 +: 16], ep[i]);
         end
         n_compared++;
         if (bus.accum[i*ACCW +: ACCW] !== ea[i]) begin
            n_mismatched++;
            $display("[TB] FAIL b8_accum[%0d]: got %h want %h", i, bus.accum[i*ACCW +: ACCW], ea[i]);
         end
      end
      tick();
      n_compared++;
      if (bus.out_valid !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL b8_pulse_width: got %b want 0", bus.out_valid);
      end
      n_compared++;
      if (bus.product[15:0] !== 16'h0406) begin
         n_mismatched++;
         $display("[TB] FAIL b8_product_hold: got %h want 0406", bus.product[15:0]);
      end
   endtask

   task automatic test_4b_2b();
      int cyc;
      logic [15:0] ep [4];
      logic [19:0] ea [4];
      pulse_clr();
      launch({8'hF8, 8'h08, 8'h07, 8'h7B}, {8'hF8, 8'h07, 8'h07, 8'h48}, 2'b01);
      bus.prec = 2'b00;
      wait_out(cyc);
      ep = '{16'h0028, 16'h0031, 16'hFFC8, 16'h0040};
      ea = '{20'h00028, 20'h00031, 20'hFFFC8, 20'h00040};
      n_compared++;
      if (cyc != 4) begin
         n_mismatched++;
         $display("[TB] FAIL b4_latency: got %0d want 4", cyc);
      end
      for (int i = 0; i < LANES; i++) begin
         n_compared++;
         if (bus.product[i*16 +: 16] !== ep[i]) begin
            n_mismatched++;
            $display("[TB] FAIL b4_product[%0d]: got %h want %h", i, bus.product[i*16 +: 16], ep[i]);
         end
         n_compared++;
         if (bus.accum[i*ACCW +: ACCW] !== ea[i]) begin
            n_mismatched++;
            $display("[TB] FAIL b4_accum[%0d]: got %h want %h", i, bus.accum[i*ACCW +: ACCW], ea[i]);
         end
      end
      launch({8'h02, 8'h02, 8'h01, 8'h03}, {8'h02, 8'h01, 8'h01, 8'h02}, 2'b10);
      wait_out(cyc);
      ep = '{16'h0002, 16'h0001, 16'hFFFE, 16'h0004};
      ea = '{20'h0002A, 20'h00032, 20'hFFFC6, 20'h00044};
      n_compared++;
      if (cyc != 2) begin
         n_mismatched++;
         $display("[TB] FAIL b2_latency: got %0d want 2", cyc);
      end
      for (int i = 0; i < LANES; i++) begin
         n_compared++;
         if (bus.product[i*16 +: 16] !== ep[i]) begin
            n_mismatched++;
            $display("[TB] FAIL b2_product[%0d]: got %h want %h", i, bus.product[i*16 +: 16], ep[i]);
         end
         n_compared++;
         if (bus.accum[i*ACCW +: ACCW] !== ea[i]) begin
            n_mismatched++;
            $display("[TB] FAIL b2_accum[%0d]: got %h want %h", i, bus.accum[i*ACCW +: ACCW], ea[i]);
         end
      end
   endtask

   task automatic test_reserved_prec();
      int cyc;
      tick();
      pulse_clr();
      launch({24'h0, 8'h67}, {24'h0, 8'h0A}, 2'b11);
      wait_out(cyc);
      n_compared++;
      if (cyc != 8) begin
         n_mismatched++;
         $display("[TB] FAIL rsvd_latency: got %0d want 8", cyc);
      end
      n_compared++;
      if (bus.product[15:0] !== 16'h0406) begin
         n_mismatched++;
         $display("[TB] FAIL rsvd_product: got %h want 0406", bus.product[15:0]);
      end
   endtask

   task automatic test_saturation();
      int n;
      int prev;
      int cyc;
      tick();
      pulse_clr();
      bus.a        = {4{8'h80}};
      bus.w        = {4{8'h80}};
      bus.prec     = 2'b00;
      bus.in_valid = 1'b1;
      n    = 0;
      prev = 0;
      for (int c = 0; c < 400 && n < 32; c++) begin
         tick();
         if (bus.out_valid === 1'b1) begin
            n++;
            if (n > 1) begin
               n_compared++;
               if (c - prev != 8) begin
                  n_mismatched++;
                  $display("[TB] FAIL sat_spacing: got %0d want 8", c - prev);
               end
            end
            prev = c;
            if (n == 31) begin
               bus.in_valid = 1'b0;
               n_compared++;
               if (bus.accum[ACCW-1:0] !== 20'h7C000 || bus.ovf[0] !== 1'b0) begin
                  n_mismatched++;
                  $display("[TB] FAIL sat_op31: got acc=%h ovf=%b want 7c000/0", bus.accum[ACCW-1:0], bus.ovf[0]);
               end
            end
            if (n == 32) begin
               n_compared++;
               if (bus.accum[ACCW-1:0] !== 20'h7FFFF || bus.ovf !== 4'hF) begin
                  n_mismatched++;
                  $display("[TB] FAIL sat_op32: got acc=%h ovf=%b want 7ffff/1111", bus.accum[ACCW-1:0], bus.ovf);
               end
            end
         end
      end
      bus.in_valid = 1'b0;
      n_compared++;
      if (n != 32) begin
         n_mismatched++;
         $display("[TB] FAIL sat_pulse_count: got %0d want 32", n);
      end
      repeat (4) tick();
      n_compared++;
      if (bus.ovf !== 4'hF || bus.accum[ACCW-1:0] !== 20'h7FFFF || bus.busy !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL sat_hold: got ovf=%b acc=%h busy=%b want 1111/7ffff/0", bus.ovf, bus.accum[ACCW-1:0], bus.busy);
      end
      launch({4{8'h80}}, {4{8'h7F}}, 2'b00);
      wait_out(cyc);
      n_compared++;
      if (bus.accum[ACCW-1:0] !== 20'h7C07F || bus.ovf[0] !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL sat_sticky: got acc=%h ovf=%b want 7c07f/1", bus.accum[ACCW-1:0], bus.ovf[0]);
      end
      pulse_clr();
      n_compared++;
      if (bus.accum !== '0 || bus.ovf !== 4'h0) begin
         n_mismatched++;
         $display("[TB] FAIL sat_clear: got acc=%h ovf=%b want 0/0000", bus.accum, bus.ovf);
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] exp_count;
      logic       exp_ready;
      logic       exp_ov;
      pulse_clr();
      bus.a        = {24'h0, 8'h03};
      bus.w        = {24'h0, 8'h03};
      bus.prec     = 2'b01;
      bus.in_valid = 1'b1;
      tick();
      for (int j = 0; j <= 13; j++) begin
         exp_count = (j < 12) ? 3'(j % 4) : 3'd0;
         exp_ready = (j < 12) ? (j % 4 == 3) : 1'b1;
         exp_ov    = (j > 0) && (j % 4 == 0);
         n_compared++;
         if (bus.count !== exp_count) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_count@%0d: got %0d want %0d", j, bus.count, exp_count);
         end
         n_compared++;
         if (bus.in_ready !== exp_ready) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_in_ready@%0d: got %b want %b", j, bus.in_ready, exp_ready);
         end
         n_compared++;
         if (bus.out_valid !== exp_ov) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_out_valid@%0d: got %b want %b", j, bus.out_valid, exp_ov);
         end
         if (j == 4 || j == 8 || j == 12) begin
            n_compared++;
            if (bus.accum[ACCW-1:0] !== ((j == 8) ? 20'd18 : 20'd9)) begin
               n_mismatched++;
               $display("[TB] FAIL b2b_accum@%0d: got %0d want %0d", j, bus.accum[ACCW-1:0], (j == 8) ? 18 : 9);
            end
         end
         if (j == 12) begin
            n_compared++;
            if (bus.product[15:0] !== 16'd9 || bus.busy !== 1'b0) begin
               n_mismatched++;
               $display("[TB] FAIL b2b_final: got prod=%0d busy=%b want 9/0", bus.product[15:0], bus.busy);
            end
         end
         if (j == 8)  bus.in_valid = 1'b0;
         if (j == 11) bus.acc_clr  = 1'b1;
         if (j == 12) bus.acc_clr  = 1'b0;
         tick();
      end
   endtask

   task automatic test_reset_mid_op();
      int   cyc;
      logic saw;
      launch({24'h0, 8'h67}, {24'h0, 8'h0A}, 2'b00);
      repeat (3) tick();
      n_compared++;
      if (bus.count !== 3'd3) begin
         n_mismatched++;
         $display("[TB] FAIL rst_mid_count: got %0d want 3", bus.count);
      end
      rstn = 1'b0;
      #1;
      n_compared++;
      if (bus.out_valid !== 1'b0 || bus.product !== '0 || bus.accum !== '0 ||
          bus.ovf !== '0 || bus.busy !== 1'b0 || bus.count !== 3'd0) begin
         n_mismatched++;
         $display("[TB] FAIL rst_mid_outputs: got ov=%b prod=%h acc=%h ovf=%b busy=%b cnt=%0d want all 0",
                  bus.out_valid, bus.product, bus.accum, bus.ovf, bus.busy, bus.count);
      end
      tick();
      rstn = 1'b1;
      saw  = 1'b0;
      repeat (10) begin
         tick();
         if (bus.out_valid === 1'b1) saw = 1'b1;
      end
      n_compared++;
      if (saw !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL rst_mid_discard: got out_valid pulse=%b want 0", saw);
      end
      launch({24'h0, 8'h67}, {24'h0, 8'h0A}, 2'b00);
      wait_out(cyc);
      n_compared++;
      if (cyc != 8 || bus.product[15:0] !== 16'h0406 || bus.accum[ACCW-1:0] !== 20'd1030) begin
         n_mismatched++;
         $display("[TB] FAIL rst_mid_next_op: got cyc=%0d prod=%h acc=%0d want 8/0406/1030",
                  cyc, bus.product[15:0], bus.accum[ACCW-1:0]);
      end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.a        = '0;
      bus.w        = '0;
      bus.prec     = 2'b00;
      bus.acc_clr  = 1'b0;
      rstn         = 1'b0;
      test_reset();
      test_8b_basic();
      test_4b_2b();
      test_reserved_prec();
      test_saturation();
      test_back_to_back();
      test_reset_mid_op();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
